// File: rtl/ssim_window_sched_if.sv
// Bundles the scheduler's control, memory-read and pixel-pair stream signals.
// master: scheduler side; slave: the memories/consumer around it.
interface ssim_window_sched_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata_x;
    logic [7:0]        mem_rdata_y;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_x;
    logic [7:0]        out_y;
    logic              out_first;
    logic              out_last;
    logic [7:0]        win_idx;

    modport master (
        input  start, mem_rdata_x, mem_rdata_y, out_ready,
        output busy, done, mem_en, mem_addr, out_valid,
               out_x, out_y, out_first, out_last, win_idx
    );

    modport slave (
        output start, mem_rdata_x, mem_rdata_y, out_ready,
        input  busy, done, mem_en, mem_addr, out_valid,
               out_x, out_y, out_first, out_last, win_idx
    );
endinterface

// File: rtl/ssim_window_sched.sv
// SSIM window scheduler: walks the X/Y images as WIN x WIN windows at STRIDE,
// reads both memories with one shared address and streams (x, y) pairs in
// window order through a 2-entry output FIFO with valid/ready backpressure.
// Optional macro SSIM_SCHED_ABORT_EN adds an abort input that cancels a pass.
module ssim_window_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int WIN    = 8,
    parameter int STRIDE = 4,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SSIM_SCHED_ABORT_EN
    input  logic                 abort,
`endif
    ssim_window_sched_if.master  bus
);
    localparam int NWX = (IMG_W - WIN) / STRIDE + 1;
    localparam int NWY = (IMG_H - WIN) / STRIDE + 1;
    localparam int AW2 = ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       first;
        logic       last;
        logic [7:0] win;
    } entry_t;

    state_t            state_r;
    logic [7:0]        px_r, py_r, wx_r, wy_r;
    logic              inflight_r;
    logic              meta_first_r, meta_last_r;
    logic [7:0]        meta_win_r;
    entry_t            fifo_r [0:1];
    logic              wr_ptr_r, rd_ptr_r;
    logic [1:0]        count_r;
    logic [ADDR_W-1:0] addr_hold_r;

    logic              abort_s;
    logic              pop_s;
    logic [2:0]        credit_s;
    logic              issue_s;
    logic              last_px_s, last_py_s, last_wx_s, last_wy_s;
    logic [AW2-1:0]    row_s, addr_full_s;
    logic [7:0]        win_s;
    entry_t            head_s;

`ifdef SSIM_SCHED_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // A read may be issued only if its data will find a free FIFO slot:
    // entries held plus the read already in flight, minus this cycle's pop.
    assign pop_s    = (count_r != 2'd0) && bus.out_ready;
    assign credit_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s  = (state_r == S_RUN) && !abort_s && (credit_s < 3'd2);

    assign last_px_s = (px_r == 8'(WIN - 1));
    assign last_py_s = (py_r == 8'(WIN - 1));
    assign last_wx_s = (wx_r == 8'(NWX - 1));
    assign last_wy_s = (wy_r == 8'(NWY - 1));

    // Address is formed two bits wider than the memory port, then truncated.
    assign row_s       = AW2'(wy_r) * AW2'(STRIDE) + AW2'(py_r);
    assign addr_full_s = row_s * AW2'(IMG_W) + AW2'(wx_r) * AW2'(STRIDE) + AW2'(px_r);
    assign win_s       = wy_r * 8'(NWX) + wx_r;

    assign head_s = fifo_r[rd_ptr_r];

    assign bus.mem_en    = issue_s;
    assign bus.mem_addr  = issue_s ? ADDR_W'(addr_full_s) : addr_hold_r;
    assign bus.busy      = (state_r == S_RUN) || (state_r == S_DRAIN);
    assign bus.done      = (state_r == S_DONE);
    assign bus.out_valid = (count_r != 2'd0);
    assign bus.out_x     = head_s.x;
    assign bus.out_y     = head_s.y;
    assign bus.out_first = head_s.first;
    assign bus.out_last  = head_s.last;
    assign bus.win_idx   = head_s.win;

    // Control FSM, window/pixel counters, read pipeline and output FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            px_r         <= 8'd0;
            py_r         <= 8'd0;
            wx_r         <= 8'd0;
            wy_r         <= 8'd0;
            inflight_r   <= 1'b0;
            meta_first_r <= 1'b0;
            meta_last_r  <= 1'b0;
            meta_win_r   <= 8'd0;
            fifo_r[0]    <= '0;
            fifo_r[1]    <= '0;
            wr_ptr_r     <= 1'b0;
            rd_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
            addr_hold_r  <= '0;
        end else if (abort_s && ((state_r == S_RUN) || (state_r == S_DRAIN))) begin
            // Cancel the pass: drop queued pairs and the read still returning.
            state_r    <= S_IDLE;
            inflight_r <= 1'b0;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                meta_first_r <= (px_r == 8'd0) && (py_r == 8'd0);
                meta_last_r  <= last_px_s && last_py_s;
                meta_win_r   <= win_s;
                addr_hold_r  <= ADDR_W'(addr_full_s);
            end
            if (inflight_r) begin
                fifo_r[wr_ptr_r] <= '{bus.mem_rdata_x, bus.mem_rdata_y,
                                      meta_first_r, meta_last_r, meta_win_r};
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};

            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        state_r <= S_RUN;
                        px_r    <= 8'd0;
                        py_r    <= 8'd0;
                        wx_r    <= 8'd0;
                        wy_r    <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (issue_s) begin
                        if (!last_px_s) begin
                            px_r <= px_r + 8'd1;
                        end else begin
                            px_r <= 8'd0;
                            if (!last_py_s) begin
                                py_r <= py_r + 8'd1;
                            end else begin
                                py_r <= 8'd0;
                                if (!last_wx_s) begin
                                    wx_r <= wx_r + 8'd1;
                                end else begin
                                    wx_r <= 8'd0;
                                    if (!last_wy_s) begin
                                        wy_r <= wy_r + 8'd1;
                                    end else begin
                                        wy_r    <= 8'd0;
                                        state_r <= S_DRAIN;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    // Finished once the last queued pair leaves via a handshake.
                    if (!inflight_r && (count_r == 2'd1) && pop_s) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ssim_window_sched.sv
// Directed bench for ssim_window_sched: image memories modelled with
// X[a]=a[7:0], Y[a]=~a[7:0]; expected pairs derived from the window walk.
module tb_ssim_window_sched;
    logic clk;
    logic rst;
    logic start;
    logic out_ready;
    logic [7:0] mem_rdata_x;
    logic [7:0] mem_rdata_y;
`ifdef SSIM_SCHED_ABORT_EN
    logic abort;
`endif
    int n_tests;
    int n_fail;

    ssim_window_sched_if #(.ADDR_W(10)) bus ();

    assign bus.start       = start;
    assign bus.out_ready   = out_ready;
    assign bus.mem_rdata_x = mem_rdata_x;
    assign bus.mem_rdata_y = mem_rdata_y;

    ssim_window_sched dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SSIM_SCHED_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            mem_rdata_x <= bus.mem_addr[7:0];
            mem_rdata_y <= ~bus.mem_addr[7:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {x, y, first, last, win_idx} of the k-th pair of a pass.
    function automatic logic [63:0] exp_pair(input int k);
        int px, py, wx, wy, a;
        logic [7:0] ax;
        px = k % 8;
        py = (k / 8) % 8;
        wx = (k / 64) % 6;
        wy = k / 384;
        a  = (wy * 4 + py) * 28 + wx * 4 + px;
        ax = a[7:0];
        return {38'd0, ax, ~ax, (k % 64 == 0), (k % 64 == 63), 8'(k / 64)};
    endfunction

    function automatic logic [39:0] all_outs();
        return {bus.busy, bus.done, bus.mem_en, bus.mem_addr, bus.out_valid,
                bus.out_x, bus.out_y, bus.out_first, bus.out_last, bus.win_idx};
    endfunction

    // mode: 0 stream, 1 ready toggling, 2 stall 20 cycles, 3 stray start,
    //       4 reset after 500 pairs, 5 abort after 70 pairs
    task automatic run_pass(input int mode);
        int hs, done_cyc, first_v, en_cnt, outst, max_out;
        bit fin, done_seen;
        hs = 0; done_cyc = -1; first_v = -1; en_cnt = 0; outst = 0; max_out = 0;
        fin = 1'b0; done_seen = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int n = 1; n <= 6000 && !fin; n++) begin
            @(negedge clk);
            if (first_v < 0 && bus.out_valid) first_v = n;
            if (outst > max_out) max_out = outst;
            start = (mode == 3 && n == 100);
            case (mode)
                1:       out_ready = (n % 2 == 1);
                2:       out_ready = !(first_v >= 0 && n < first_v + 20);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && first_v >= 0 && n < first_v + 20)
                chk("stall_hold", {bus.out_valid, bus.out_x, bus.out_y, bus.out_first},
                    {1'b1, 8'h00, 8'hFF, 1'b1});
            #1;
            if (bus.mem_en) begin
                en_cnt++;
                outst++;
            end
            if (mode == 2 && n == first_v + 19) chk("stall_mem_en", en_cnt, 2);
            if (bus.done) begin
                done_cyc = n;
                fin      = 1'b1;
            end
            if (bus.out_valid && out_ready) begin
                chk("pair", {38'd0, bus.out_x, bus.out_y, bus.out_first, bus.out_last,
                             bus.win_idx}, exp_pair(hs));
                if (hs == 0)    chk("first_pair", {bus.out_x, bus.out_first, bus.win_idx},
                                    {8'd0, 1'b1, 8'd0});
                if (hs == 8)    chk("w0_row1_addr", bus.out_x, 8'd28);
                if (hs == 63)   chk("w0_last_addr", {bus.out_x, bus.out_last}, {8'd203, 1'b1});
                if (hs == 64)   chk("w1_start_addr", bus.out_x, 8'd4);
                if (hs == 384)  chk("w6_start_addr", {bus.out_x, bus.win_idx}, {8'd112, 8'd6});
                if (hs == 2303) chk("final_pair", {bus.out_x, bus.out_y, bus.out_last, bus.win_idx},
                                    {8'h0F, 8'hF0, 1'b1, 8'd35});
                hs++;
                outst--;
                if (mode == 4 && hs == 500) begin
                    rst = 1'b0;
                    fin = 1'b1;
                end
`ifdef SSIM_SCHED_ABORT_EN
                if (mode == 5 && hs == 70) begin
                    abort = 1'b1;
                    fin   = 1'b1;
                end
`endif
            end
        end
        chk("pass_end", fin, 1'b1);
        if (mode == 4) begin
            @(negedge clk);
            chk("rst_outputs", all_outs(), 40'd0);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_discard", {bus.out_valid, bus.busy}, 2'b00);
        end else if (mode == 5) begin
`ifdef SSIM_SCHED_ABORT_EN
            @(negedge clk);
            abort = 1'b0;
            chk("abort_flush", {bus.out_valid, bus.busy}, 2'b00);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.done) done_seen = 1'b1;
            end
            chk("abort_no_done", done_seen, 1'b0);
`endif
        end else begin
            chk("pair_count", hs, 2304);
            chk("fifo_max", max_out, 2);
            if (mode == 0) chk("first_valid_cyc", first_v, 3);
            if (mode == 0 || mode == 3) chk("done_cyc", done_cyc, 2307);
            if (mode == 2) chk("done_cyc_stall", done_cyc, 2327);
            @(negedge clk);
            chk("done_pulse", {bus.done, bus.busy}, 2'b00);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
`ifdef SSIM_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_state", all_outs(), 40'd0);
        rst = 1'b1;
        @(negedge clk);
        run_pass(0);
        run_pass(1);
        run_pass(2);
        run_pass(3);
        run_pass(4);
        run_pass(0);
`ifdef SSIM_SCHED_ABORT_EN
        run_pass(5);
        run_pass(0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
